// File: rtl/mux4to1_rr_if.sv
// mux4to1_rr_if
//   Bundles the four valid/ready source channels and the single merged output
//   stream of the round-robin 4-to-1 multiplexer.
//   Ports carried:
//     in_valid  [3:0]    per-channel valid, bit i = channel i
//     in_data   [4*W-1:0] channel i data at in_data[i*W +: W]
//     in_ready  [3:0]    per-channel ready (one-hot or zero)
//     out_valid          output word present
//     out_data  [W-1:0]  output word
//     out_sel   [1:0]    source channel index of out_data
//     out_ready          downstream accepts the output word
//   Modports:
//     slave  - the multiplexer itself
//     master - the environment (sources plus downstream sink)
interface mux4to1_rr_if #(
  parameter int W = 1
);
  logic [3:0]     in_valid;
  logic [4*W-1:0] in_data;
  logic [3:0]     in_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic [1:0]     out_sel;
  logic           out_ready;

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready,
    output out_valid,
    output out_data,
    output out_sel,
    input  out_ready
  );

  modport master (
    output in_valid,
    output in_data,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_sel,
    output out_ready
  );
endinterface

// File: rtl/mux4to1_rr.sv
// mux4to1_rr
//   Merges four independent valid/ready sources onto one registered output
//   stream with round-robin arbitration. Every output word is tagged with its
//   source channel (out_sel) so a downstream 1-to-4 demux can split it again.
//   Ports:
//     clk    - single clock, rising edge
//     rst_n  - asynchronous, active-low reset
//     bus    - mux4to1_rr_if.slave carrying the source channels and the output
//   Latency is one cycle from input handshake to out_valid; a word can drain
//   and a new one be captured on the same edge, giving one word per cycle.
module mux4to1_rr #(
  parameter int W = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  mux4to1_rr_if.slave   bus
);

  logic         out_valid_q;
  logic [W-1:0] out_data_q;
  logic [1:0]   out_sel_q;
  logic [1:0]   ptr_q;          // last granted channel

  logic         can_accept;
  logic         grant_found;
  logic [1:0]   grant_idx;
  logic [1:0]   cand;
  logic         xfer;

  // The output register is free when empty or being drained on this edge.
  assign can_accept = !out_valid_q || bus.out_ready;

  // Search ptr+1, ptr+2, ptr+3, ptr (mod 4); first requester wins. The 2-bit
  // addition wraps naturally, so k=4 lands back on ptr itself (lowest priority).
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = ptr_q;
    cand        = ptr_q;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!grant_found && bus.in_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  // Ready is withheld while reset is asserted so no source sees a handshake
  // into a register that is being cleared.
  assign xfer         = rst_n && can_accept && grant_found;
  assign bus.in_ready = xfer ? (4'b0001 << grant_idx) : 4'b0000;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= 2'b00;
      ptr_q       <= 2'b11;     // channel 0 gets first priority after reset
    end else if (xfer) begin
      out_valid_q <= 1'b1;
      out_data_q  <= bus.in_data[int'(grant_idx)*W +: W];
      out_sel_q   <= grant_idx;
      ptr_q       <= grant_idx;
    end else if (bus.out_ready) begin
      // Drained with nothing to replace it; data/sel keep their last values.
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;

endmodule
